// File: rtl/ysyx_24080014_wbu.sv
// Write-back unit: takes one executed instruction from the EXU, finishes loads
// (align + extend), then presents a one-cycle register/CSR write and retire pulse.
module ysyx_24080014_wbu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // EXU side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic              in_is_load,
  input  logic [2:0]        in_load_fn,
  input  logic [1:0]        in_csrs_ctl,
  input  logic [11:0]       in_csr_wadd,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_next_pc,
  // memory read response
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rerr,
  // GPR / CSR write port
  output logic              RegWr,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   rd_data,
  output logic [1:0]        csrs_ctl,
  output logic [11:0]       csrs_rs1_write_add,
  output logic [XLEN-1:0]   pc,
  // IFU side
  output logic              commit,
  output logic [XLEN-1:0]   next_pc,
  output logic              wb_err,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int NB = XLEN / 8;

  localparam logic [2:0] FN_LB  = 3'b000;
  localparam logic [2:0] FN_LH  = 3'b001;
  localparam logic [2:0] FN_LW  = 3'b010;
  localparam logic [2:0] FN_LBU = 3'b100;
  localparam logic [2:0] FN_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [4:0]       rd_q, rd_d;
  logic             rd_wen_q, rd_wen_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       load_fn_q, load_fn_d;
  logic [1:0]       csrs_ctl_q, csrs_ctl_d;
  logic [11:0]      csr_wadd_q, csr_wadd_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  next_pc_q, next_pc_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             load_legal;
  logic [7:0]       byte_lane [NB];
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [XLEN-1:0]  load_ext;

  assign in_ready   = (state_q == S_IDLE);
  assign mem_rready = (state_q == S_WAIT_MEM);
  assign accept     = in_valid & in_ready;

  // Alignment / funct3 legality of the incoming load, judged on the effective address.
  always_comb begin
    load_legal = 1'b0;
    case (in_load_fn)
      FN_LB, FN_LBU: load_legal = 1'b1;
      FN_LH, FN_LHU: load_legal = ~in_alu_res[0];
      FN_LW:         load_legal = (in_alu_res[1:0] == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  end

  // Byte lanes of the returned word; the half select only ever uses offsets 0 and 2.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign byte_lane[gi] = mem_rdata[8*gi +: 8];
  end

  assign sel_byte = byte_lane[off_q];
  assign sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    case (load_fn_q)
      FN_LB:   load_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      FN_LBU:  load_ext = {{(XLEN-8){1'b0}}, sel_byte};
      FN_LH:   load_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
      FN_LHU:  load_ext = {{(XLEN-16){1'b0}}, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (in_is_load && load_legal) ? S_WAIT_MEM : S_COMMIT;
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Captured instruction fields and load result
  always_comb begin
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    off_d      = off_q;
    load_fn_d  = load_fn_q;
    csrs_ctl_d = csrs_ctl_q;
    csr_wadd_d = csr_wadd_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    data_d     = data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (accept) begin
      rd_d       = in_rd;
      rd_wen_d   = in_rd_wen;
      off_d      = in_alu_res[1:0];
      load_fn_d  = in_load_fn;
      csrs_ctl_d = in_csrs_ctl;
      csr_wadd_d = in_csr_wadd;
      pc_d       = in_pc;
      next_pc_d  = in_next_pc;
      data_d     = in_alu_res;
      err_d      = in_is_load & ~load_legal;
    end
    if (state_q == S_WAIT_MEM && mem_rvalid) begin
      data_d = load_ext;
      err_d  = mem_rerr;
    end
    if (state_q == S_COMMIT && !err_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      off_q      <= '0;
      load_fn_q  <= '0;
      csrs_ctl_q <= '0;
      csr_wadd_q <= '0;
      pc_q       <= '0;
      next_pc_q  <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      off_q      <= off_d;
      load_fn_q  <= load_fn_d;
      csrs_ctl_q <= csrs_ctl_d;
      csr_wadd_q <= csr_wadd_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output logic: everything toward GPR/IFU is zero except in the single COMMIT cycle.
  always_comb begin
    RegWr              = 1'b0;
    rd                 = '0;
    rd_data            = '0;
    csrs_ctl           = '0;
    csrs_rs1_write_add = '0;
    pc                 = '0;
    commit             = 1'b0;
    next_pc            = '0;
    wb_err             = 1'b0;
    if (state_q == S_COMMIT) begin
      RegWr              = rd_wen_q & ~err_q;
      rd                 = rd_q;
      rd_data            = data_q;
      csrs_ctl           = csrs_ctl_q;
      csrs_rs1_write_add = csr_wadd_q;
      pc                 = pc_q;
      commit             = 1'b1;
      next_pc            = next_pc_q;
      wb_err             = err_q;
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Randomized bench for ysyx_24080014_wbu against a behavioural model of load
// extension, alignment legality, commit timing and the retire counter.
module tb_ysyx_24080014_wbu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_alu_res;
  logic        in_is_load;
  logic [2:0]  in_load_fn;
  logic [1:0]  in_csrs_ctl;
  logic [11:0] in_csr_wadd;
  logic [31:0] in_pc;
  logic [31:0] in_next_pc;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        RegWr;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [1:0]  csrs_ctl;
  logic [11:0] csrs_rs1_write_add;
  logic [31:0] pc;
  logic        commit;
  logic [31:0] next_pc;
  logic        wb_err;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;
  longint unsigned model_cnt = 0;

  always #5 clk = ~clk;

  ysyx_24080014_wbu #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_alu_res(in_alu_res), .in_is_load(in_is_load), .in_load_fn(in_load_fn),
    .in_csrs_ctl(in_csrs_ctl), .in_csr_wadd(in_csr_wadd), .in_pc(in_pc),
    .in_next_pc(in_next_pc),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rerr(mem_rerr),
    .RegWr(RegWr), .rd(rd), .rd_data(rd_data), .csrs_ctl(csrs_ctl),
    .csrs_rs1_write_add(csrs_rs1_write_add), .pc(pc), .commit(commit),
    .next_pc(next_pc), .wb_err(wb_err), .retire_cnt(retire_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference rules, written as arithmetic on the word rather than bit slicing.
  function automatic bit model_legal(input int unsigned fn, input int unsigned off);
    case (fn)
      0, 4:    return 1'b1;
      1, 5:    return (off % 2) == 0;
      2:       return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int unsigned fn, input int unsigned off,
                                             input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (off * 8)) % 256;
    h = (word >> ((off / 2) * 16)) % 65536;
    case (fn)
      0:       return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      4:       return 32'(b);
      1:       return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      5:       return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
    check_eq({tag, ".mem_rready"}, mem_rready, 1'b0);
    check_eq({tag, ".commit"}, commit, 1'b0);
    check_eq({tag, ".RegWr"}, RegWr, 1'b0);
    check_eq({tag, ".wb_err"}, wb_err, 1'b0);
    check_eq({tag, ".rd"}, rd, 5'd0);
    check_eq({tag, ".rd_data"}, rd_data, 32'd0);
    check_eq({tag, ".csrs_ctl"}, csrs_ctl, 2'd0);
    check_eq({tag, ".csr_wadd"}, csrs_rs1_write_add, 12'd0);
    check_eq({tag, ".retire_cnt"}, retire_cnt, model_cnt[31:0]);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input bit is_load, input logic [2:0] fn, input logic [31:0] alu,
                         input logic [4:0] rdi, input bit wen, input logic [1:0] ctl,
                         input logic [11:0] wadd, input logic [31:0] pcv,
                         input logic [31:0] npc, input int wait_cycles,
                         input logic [31:0] word, input bit rerr);
    bit          legal;
    bit          exp_err;
    logic [31:0] exp_data;
    legal    = model_legal(fn, alu % 4);
    exp_err  = is_load && (!legal || rerr);
    exp_data = is_load ? model_load(fn, alu % 4, word) : alu;

    check_eq("accept.in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_is_load = is_load; in_load_fn = fn; in_alu_res = alu;
    in_rd = rdi; in_rd_wen = wen; in_csrs_ctl = ctl; in_csr_wadd = wadd;
    in_pc = pcv; in_next_pc = npc;
    mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom; mem_rerr = 1'($urandom % 2);
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;

    if (is_load && legal) begin
      for (int w = 0; w < wait_cycles; w++) begin
        check_eq("wait.mem_rready", mem_rready, 1'b1);
        check_eq("wait.in_ready", in_ready, 1'b0);
        check_eq("wait.commit", commit, 1'b0);
        check_eq("wait.RegWr", RegWr, 1'b0);
        in_valid = 1'($urandom % 2);
        mem_rdata = $urandom;
        @(negedge clk);
      end
      check_eq("resp.mem_rready", mem_rready, 1'b1);
      in_valid = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = word; mem_rerr = rerr;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rerr = 1'b0;
    end

    check_eq("commit.commit", commit, 1'b1);
    check_eq("commit.RegWr", RegWr, wen && !exp_err);
    check_eq("commit.wb_err", wb_err, exp_err);
    check_eq("commit.rd", rd, rdi);
    check_eq("commit.csrs_ctl", csrs_ctl, ctl);
    check_eq("commit.csr_wadd", csrs_rs1_write_add, wadd);
    check_eq("commit.pc", pc, pcv);
    check_eq("commit.next_pc", next_pc, npc);
    check_eq("commit.in_ready", in_ready, 1'b0);
    check_eq("commit.mem_rready", mem_rready, 1'b0);
    check_eq("commit.retire_cnt", retire_cnt, model_cnt[31:0]);
    if (!exp_err) check_eq("commit.rd_data", rd_data, exp_data);
    $display("txn %0d: load=%0d fn=%0d addr=%08h rd=%0d wen=%0d ctl=%0d wait=%0d rerr=%0d err=%0d data=%08h",
             txn_no, is_load, fn, alu, rdi, wen, ctl, wait_cycles, rerr, exp_err, rd_data);
    txn_no++;
    if (!exp_err) model_cnt = (model_cnt + 1) % (64'd1 << 32);
    mem_rvalid = 1'($urandom % 2);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_idle_outputs("after");
  endtask

  initial begin
    int unsigned fn_tab [8] = '{0, 1, 2, 4, 5, 3, 6, 7};
    rst_n = 1'b0;
    in_valid = 0; in_rd = 0; in_rd_wen = 0; in_alu_res = 0; in_is_load = 0;
    in_load_fn = 0; in_csrs_ctl = 0; in_csr_wadd = 0; in_pc = 0; in_next_pc = 0;
    mem_rvalid = 0; mem_rdata = 0; mem_rerr = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset.pc", pc, 32'd0);
    check_eq("reset.next_pc", next_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn(0, 3'd0, 32'h0000_1234, 5'd5, 1, 2'd0, 12'h000, 32'h8000_0000, 32'h8000_0004, 0, 32'h0, 0);
    run_txn(1, 3'd0, 32'h0000_1001, 5'd6, 1, 2'd0, 12'h000, 32'h8000_0004, 32'h8000_0008, 1, 32'h1180_2233, 0);
    run_txn(1, 3'd0, 32'h0000_1002, 5'd6, 1, 2'd0, 12'h000, 32'h8000_0008, 32'h8000_000c, 0, 32'h1180_2233, 0);
    run_txn(1, 3'd4, 32'h0000_1002, 5'd7, 1, 2'd0, 12'h000, 32'h8000_000c, 32'h8000_0010, 2, 32'h1180_2233, 0);
    run_txn(1, 3'd1, 32'h0000_1002, 5'd8, 1, 2'd0, 12'h000, 32'h8000_0010, 32'h8000_0014, 0, 32'h1180_2233, 0);
    run_txn(1, 3'd1, 32'h0000_1000, 5'd8, 1, 2'd0, 12'h000, 32'h8000_0014, 32'h8000_0018, 0, 32'h1180_8233, 0);
    run_txn(1, 3'd2, 32'h0000_1002, 5'd9, 1, 2'd0, 12'h000, 32'h8000_0018, 32'h8000_001c, 0, 32'h0, 0);
    run_txn(1, 3'd5, 32'h0000_1003, 5'd9, 1, 2'd0, 12'h000, 32'h8000_001c, 32'h8000_0020, 0, 32'h0, 0);
    run_txn(1, 3'd2, 32'h0000_2000, 5'd10, 1, 2'd0, 12'h000, 32'h8000_0020, 32'h8000_0024, 5, 32'hDEAD_BEEF, 1);
    run_txn(1, 3'd2, 32'h0000_2000, 5'd10, 1, 2'd0, 12'h000, 32'h8000_0024, 32'h8000_0028, 0, 32'hDEAD_BEEF, 0);
    run_txn(0, 3'd0, 32'h0000_0000, 5'd0, 1, 2'd1, 12'h341, 32'h8000_0028, 32'h8000_0100, 0, 32'h0, 0);
    run_txn(0, 3'd0, 32'h0000_0000, 5'd0, 0, 2'd2, 12'h300, 32'h8000_0100, 32'h8000_002c, 0, 32'h0, 0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      bit          ld;
      logic [2:0]  fn;
      ld = 1'($urandom % 2);
      fn = 3'(($urandom % 8 == 0) ? fn_tab[5 + $urandom % 3] : fn_tab[$urandom % 5]);
      run_txn(ld, fn, $urandom, 5'($urandom), 1'($urandom % 4 != 0), 2'($urandom % 3),
              12'($urandom), $urandom, $urandom, int'($urandom % 5), $urandom,
              ($urandom % 8) == 0);
    end

    // Reset while a load is waiting for memory
    check_eq("rst.pre_cnt_nonzero", retire_cnt != 0, 1'b1);
    in_valid = 1'b1; in_is_load = 1'b1; in_load_fn = 3'd2; in_alu_res = 32'h0000_4000;
    in_rd = 5'd3; in_rd_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rst.mem_rready", mem_rready, 1'b1);
    #2 rst_n = 1'b0;
    model_cnt = 0;
    #1 check_idle_outputs("rst.during");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs("rst.after");
    end
    mem_rvalid = 1'b0;
    run_txn(0, 3'd0, 32'h0000_0055, 5'd4, 1, 2'd0, 12'h000, 32'h8000_0200, 32'h8000_0204, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
